// File: rtl/vga_text_pkg.sv
// vga_text_pkg: shared cell layout, font geometry and colour constants for the text renderer
package vga_text_pkg;
  localparam int CH_LSB = 0;
  localparam int CH_W = 7;
  localparam int FG_LSB = 7;
  localparam int BLINK_BIT = 10;
  localparam int CELL_W = 11;
  localparam int FONT_W = 8;
  localparam int FONT_H = 16;
  localparam int FONT_ADDR_W = 11;
  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] WHITE = 3'b111;
  localparam logic [2:0] RED = 3'b100;
endpackage

// File: rtl/font_rom.sv
// font_ROM: synchronous 8x16 glyph ROM, addr = {char, glyph_row}, MSB is the leftmost pixel
module font_ROM (
  input  logic        clk,
  input  logic [10:0] addr,
  output logic [7:0]  data
);
  logic [7:0] word;
  always_comb begin
    word = 8'h00;
    case (addr)
      11'h412: word = 8'h10;
      11'h413: word = 8'h38;
      11'h414: word = 8'h6c;
      11'h415: word = 8'hc6;
      11'h416: word = 8'hc6;
      11'h417: word = 8'hfe;
      11'h418: word = 8'hc6;
      11'h419: word = 8'hc6;
      11'h41a: word = 8'hc6;
      11'h41b: word = 8'hc6;
      11'h422: word = 8'hfc;
      11'h423: word = 8'h66;
      11'h424: word = 8'h66;
      11'h425: word = 8'h66;
      11'h426: word = 8'h7c;
      11'h427: word = 8'h66;
      11'h428: word = 8'h66;
      11'h429: word = 8'h66;
      11'h42a: word = 8'h66;
      11'h42b: word = 8'hfc;
      11'h522: word = 8'hfc;
      11'h523: word = 8'h66;
      11'h524: word = 8'h66;
      11'h525: word = 8'h66;
      11'h526: word = 8'h7c;
      11'h527: word = 8'h6c;
      11'h528: word = 8'h66;
      11'h529: word = 8'h66;
      11'h52a: word = 8'h66;
      11'h52b: word = 8'he6;
      default: word = 8'h00;
    endcase
  end
  always_ff @(posedge clk) data <= word;
endmodule

// File: rtl/text_buffer_ram.sv
// text_buffer_ram: simple dual-port character buffer, synchronous read-first, out-of-range writes dropped
module text_buffer_ram #(
  parameter int DEPTH = 600,
  parameter int W = 11,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic [AW-1:0] ra,
  output logic [W-1:0]  rd
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we && {1'b0, wa} < (AW+1)'(DEPTH)) mem[wa] <= wd;
    rd <= mem[ra];
  end
endmodule

// File: rtl/vga_text_tile_engine.sv
// vga_text_tile_engine: 3-stage text-mode renderer (buffer read, font read, colour) with alarm blink
module vga_text_tile_engine
  import vga_text_pkg::*;
#(
  parameter int COLS = 40,
  parameter int ROWS = 15,
  parameter int SX_LOG2 = 1,
  parameter int SY_LOG2 = 1,
  parameter int COLOR_W = 3,
  parameter logic [COLOR_W-1:0] BG_COLOR = WHITE,
  parameter logic [COLOR_W-1:0] ALARM_COLOR = RED,
  parameter int BLINK_LOG2 = 5,
  localparam int CELLS = COLS * ROWS,
  localparam int AW = $clog2(CELLS)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               video_on,
  input  logic [9:0]         pixel_x,
  input  logic [9:0]         pixel_y,
  input  logic               frame_tick,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [CELL_W-1:0]  wr_data,
  input  logic               alarm_set,
  input  logic               alarm_clr,
  output logic [COLOR_W-1:0] rgb_text,
  output logic               alarm_active
);
  if ((COLS << (3 + SX_LOG2)) > 1024 || (ROWS << (4 + SY_LOG2)) > 1024) begin : g_bad_geometry
    $error("text grid does not fit a 1024x1024 pixel space");
  end
  localparam int GR_W = $clog2(FONT_H);
  localparam int GB_W = $clog2(FONT_W);
  logic [9:0] col, row;
  logic [GR_W-1:0] glyph_row, gr1;
  logic [GB_W-1:0] glyph_bit, gb1, gb2;
  logic in_range, inr1, inr2, vid1, vid2, blink2, font_bit;
  logic [AW-1:0] rd_addr;
  logic [CELL_W-1:0] cell_q;
  logic [FONT_W-1:0] font_word;
  logic [2:0] fg2;
  logic [BLINK_LOG2-1:0] blink_cnt;
  logic [COLOR_W-1:0] rgb_nx;
  assign col = pixel_x >> (3 + SX_LOG2);
  assign row = pixel_y >> (4 + SY_LOG2);
  assign glyph_row = pixel_y[3+SY_LOG2:SY_LOG2];
  assign glyph_bit = pixel_x[2+SX_LOG2:SX_LOG2];
  assign in_range = col < 10'(COLS) && row < 10'(ROWS);
  // off-grid pixels read cell 0 so the RAM index never leaves its depth
  assign rd_addr = in_range ? AW'(row * COLS + col) : '0;
  text_buffer_ram #(.DEPTH(CELLS), .W(CELL_W)) u_buf (
    .clk(clk), .we(wr_en), .wa(wr_addr), .wd(wr_data), .ra(rd_addr), .rd(cell_q)
  );
  font_ROM u_font (
    .clk(clk), .addr(FONT_ADDR_W'({cell_q[CH_LSB +: CH_W], gr1})), .data(font_word)
  );
  assign font_bit = font_word[~gb2];
  always_comb begin
    rgb_nx = !vid2 ? BLACK : (!inr2 || !font_bit) ? BG_COLOR :
             (blink2 && alarm_active && blink_cnt[BLINK_LOG2-1]) ? ALARM_COLOR : COLOR_W'(fg2);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {gr1, gb1, inr1, vid1} <= '0;
      {fg2, blink2, gb2, inr2, vid2} <= '0;
      rgb_text <= '0;
      blink_cnt <= '0;
      alarm_active <= 1'b0;
    end else begin
      {gr1, gb1, inr1, vid1} <= {glyph_row, glyph_bit, in_range, video_on};
      {fg2, blink2, gb2, inr2, vid2} <= {cell_q[FG_LSB +: 3], cell_q[BLINK_BIT], gb1, inr1, vid1};
      rgb_text <= rgb_nx;
      blink_cnt <= blink_cnt + BLINK_LOG2'(frame_tick);
      alarm_active <= alarm_set | (alarm_active & ~alarm_clr);
    end
  end
endmodule
